// File: rtl/seven_seg_scan_decoder.sv
// Scan-side monitor for a multiplexed, active-low 8-digit seven-segment bus: recovers digit values into frames.
// Optional macro SEG_HEX_EN adds decoding of hex glyphs A..F.
module seven_seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  anode_activate,
  input  logic [6:0]  led_out,
  output logic [31:0] frame_digits,
  output logic [7:0]  frame_blank,
  output logic        frame_valid,
  output logic        invalid_seen,
  output logic        multi_anode_seen,
  output logic        scan_stall
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]    SETTLE_C = 8'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {WAIT_STABLE, HOLD} state_t;

  state_t         state_q;
  logic [14:0]    samp_q;
  logic [7:0]     stable_cnt_q, stable_cnt_d;
  logic [7:0]     seen_q, seen_d;
  logic [31:0]    digit_buf_q;
  logic [7:0]     blank_buf_q;
  logic [TW-1:0]  tmo_cnt_q;
  logic           done_q;
  logic [31:0]    frame_digits_q;
  logic [7:0]     frame_blank_q;
  logic           frame_valid_q, invalid_q, multi_q, stall_q;

  logic           evaluate, capture, multi_hit, timeout;
  logic [3:0]     low_cnt;
  logic [2:0]     cap_idx;
  logic [5:0]     dec;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
  endfunction

  function automatic logic [3:0] low_count(input logic [7:0] an);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, ~an[i]};
    return cnt;
  endfunction

  function automatic logic [2:0] low_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) if (!an[i]) idx = 3'(i);
    return idx;
  endfunction

  // Result packs {invalid, blank, value}.
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: return {2'b00, 4'h0};
      7'b1001111: return {2'b00, 4'h1};
      7'b0010010: return {2'b00, 4'h2};
      7'b0000110: return {2'b00, 4'h3};
      7'b1001100: return {2'b00, 4'h4};
      7'b0100100: return {2'b00, 4'h5};
      7'b0100000: return {2'b00, 4'h6};
      7'b0001111: return {2'b00, 4'h7};
      7'b0000000: return {2'b00, 4'h8};
      7'b0000100: return {2'b00, 4'h9};
      7'b1111111: return {2'b01, 4'hF};
`ifdef SEG_HEX_EN
      7'b0001000: return {2'b00, 4'hA};
      7'b1100000: return {2'b00, 4'hB};
      7'b0110001: return {2'b00, 4'hC};
      7'b1000010: return {2'b00, 4'hD};
      7'b0110000: return {2'b00, 4'hE};
      7'b0111000: return {2'b00, 4'hF};
`endif
      default:    return {2'b10, 4'hE};
    endcase
  endfunction

  always_comb begin
    stable_cnt_d = ({anode_activate, led_out} == samp_q) ? sat_inc(stable_cnt_q) : 8'd0;
    low_cnt      = low_count(samp_q[14:7]);
    cap_idx      = low_index(samp_q[14:7]);
    dec          = seg_decode(samp_q[6:0]);
    evaluate     = (state_q == WAIT_STABLE) && (stable_cnt_q == SETTLE_C);
    capture      = evaluate && (low_cnt == 4'd1);
    multi_hit    = evaluate && (low_cnt >= 4'd2);
    timeout      = (tmo_cnt_q == TMO_LAST);
    seen_d       = seen_q | (8'b1 << cap_idx);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= WAIT_STABLE;
      samp_q         <= '1;
      stable_cnt_q   <= '0;
      seen_q         <= '0;
      digit_buf_q    <= '0;
      blank_buf_q    <= '0;
      tmo_cnt_q      <= '0;
      done_q         <= 1'b0;
      frame_digits_q <= '0;
      frame_blank_q  <= '0;
      frame_valid_q  <= 1'b0;
      invalid_q      <= 1'b0;
      multi_q        <= 1'b0;
      stall_q        <= 1'b0;
    end else begin
      // stage p0: sample the bus and track how long it has been steady
      samp_q       <= {anode_activate, led_out};
      stable_cnt_q <= stable_cnt_d;

      // stage p1: capture / classify the settled sample
      case (state_q)
        WAIT_STABLE: if (capture || multi_hit) state_q <= HOLD;
        HOLD:        if (stable_cnt_q == 8'd0) state_q <= WAIT_STABLE;
        default:     state_q <= WAIT_STABLE;
      endcase

      if (multi_hit) multi_q <= 1'b1;

      done_q <= capture && (seen_d == 8'hFF);
      if (capture) begin
        digit_buf_q[{cap_idx, 2'b00} +: 4] <= dec[3:0];
        blank_buf_q[cap_idx]               <= dec[4];
        seen_q                             <= seen_d;
        tmo_cnt_q                          <= '0;
        stall_q                            <= 1'b0;
        if (dec[5]) invalid_q <= 1'b1;
      end else if (timeout) begin
        seen_q  <= '0;
        stall_q <= 1'b1;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end

      // stage p2: publish the completed frame
      frame_valid_q <= done_q;
      if (done_q) begin
        frame_digits_q <= digit_buf_q;
        frame_blank_q  <= blank_buf_q;
        seen_q         <= '0;
      end
    end
  end

  assign frame_digits     = frame_digits_q;
  assign frame_blank      = frame_blank_q;
  assign frame_valid      = frame_valid_q;
  assign invalid_seen     = invalid_q;
  assign multi_anode_seen = multi_q;
  assign scan_stall       = stall_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder (SETTLE_CYCLES=4, TIMEOUT_CYCLES=64); honours SEG_HEX_EN.
module tb_seven_seg_scan_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  anode_activate = 8'hFF;
  logic [6:0]  led_out = 7'h7F;
  logic [31:0] frame_digits;
  logic [7:0]  frame_blank;
  logic        frame_valid, invalid_seen, multi_anode_seen, scan_stall;

  int n_checks = 0;
  int n_err    = 0;
  int fv_cnt   = 0;
  int fv_base  = 0;
  logic [6:0] pat [8];

  seven_seg_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .reset(reset), .anode_activate(anode_activate), .led_out(led_out),
    .frame_digits(frame_digits), .frame_blank(frame_blank), .frame_valid(frame_valid),
    .invalid_seen(invalid_seen), .multi_anode_seen(multi_anode_seen), .scan_stall(scan_stall)
  );

  always #5 clock = ~clock;
  always @(negedge clock) if (frame_valid === 1'b1) fv_cnt++;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;  default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic show(input int d, input logic [6:0] seg, input int n);
    anode_activate = ~(8'b1 << d);
    led_out        = seg;
    tick(n);
  endtask

  task automatic idle(input int n);
    anode_activate = 8'hFF;
    led_out        = 7'h7F;
    tick(n);
  endtask

  task automatic scan(input int lo, input int hi, input int n);
    for (int d = lo; d <= hi; d++) show(d, pat[d], n);
  endtask

  task automatic set_pats();
    for (int i = 0; i < 8; i++) pat[i] = seg_of(i + 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    set_pats();
    do_reset();
    check("rst_digits", frame_digits, 32'h0);
    check("rst_blank", {24'h0, frame_blank}, 32'h0);
    check("rst_valid", {31'h0, frame_valid}, 32'h0);
    check("rst_invalid", {31'h0, invalid_seen}, 32'h0);
    check("rst_multi", {31'h0, multi_anode_seen}, 32'h0);
    check("rst_stall", {31'h0, scan_stall}, 32'h0);

    // full scan 1..8
    fv_base = fv_cnt;
    scan(0, 7, 8);
    idle(4);
    check("scan_fv", fv_cnt - fv_base, 1);
    check("scan_digits", frame_digits, 32'h87654321);
    check("scan_blank", {24'h0, frame_blank}, 32'h0);
    check("scan_invalid", {31'h0, invalid_seen}, 32'h0);
    check("scan_multi", {31'h0, multi_anode_seen}, 32'h0);
    check("scan_stall", {31'h0, scan_stall}, 32'h0);

    // upper four digits blank
    for (int i = 4; i < 8; i++) pat[i] = 7'b1111111;
    fv_base = fv_cnt;
    scan(0, 7, 8);
    idle(4);
    check("blank_fv", fv_cnt - fv_base, 1);
    check("blank_mask", {24'h0, frame_blank}, 32'hF0);
    check("blank_hi", {16'h0, frame_digits[31:16]}, 32'hFFFF);
    check("blank_digits", frame_digits, 32'hFFFF4321);
    set_pats();

    // short holds never settle -> timeout clears partial frame
    fv_base = fv_cnt;
    scan(0, 3, 8);
    for (int k = 0; k < 20; k++) show(k % 8, pat[k % 8], 4);
    check("tmo_stall_set", {31'h0, scan_stall}, 32'h1);
    check("tmo_fv", fv_cnt - fv_base, 0);
    check("tmo_digits_kept", frame_digits, 32'hFFFF4321);
    show(4, pat[4], 8);
    check("tmo_stall_clr", {31'h0, scan_stall}, 32'h0);
    scan(5, 7, 8);
    idle(4);
    check("tmo_partial_fv", fv_cnt - fv_base, 0);
    idle(70);
    check("tmo_stall_again", {31'h0, scan_stall}, 32'h1);

    // two anodes low: flagged, seen untouched
    fv_base = fv_cnt;
    scan(0, 6, 8);
    anode_activate = 8'b11111100;
    led_out        = pat[5];
    tick(8);
    check("multi_flag", {31'h0, multi_anode_seen}, 32'h1);
    check("multi_fv_none", fv_cnt - fv_base, 0);
    show(7, pat[7], 8);
    idle(4);
    check("multi_fv", fv_cnt - fv_base, 1);
    check("multi_digits", frame_digits, 32'h87654321);
    check("multi_invalid", {31'h0, invalid_seen}, 32'h0);

    // reset mid-frame discards partial capture
    scan(0, 5, 8);
    do_reset();
    check("mid_rst_digits", frame_digits, 32'h0);
    check("mid_rst_multi", {31'h0, multi_anode_seen}, 32'h0);
    fv_base = fv_cnt;
    scan(6, 7, 8);
    idle(4);
    check("mid_rst_fv_none", fv_cnt - fv_base, 0);
    scan(0, 7, 8);
    idle(4);
    check("mid_rst_fv", fv_cnt - fv_base, 1);
    check("mid_rst_digits2", frame_digits, 32'h87654321);

    // hex glyph A on digit 2
    pat[2] = 7'b0001000;
    fv_base = fv_cnt;
    scan(0, 7, 8);
    idle(4);
    check("hex_fv", fv_cnt - fv_base, 1);
`ifdef SEG_HEX_EN
    check("hex_digits", frame_digits, 32'h87654A21);
    check("hex_invalid", {31'h0, invalid_seen}, 32'h0);
`else
    check("hex_digits", frame_digits, 32'h87654E21);
    check("hex_invalid", {31'h0, invalid_seen}, 32'h1);
`endif
    set_pats();

    // undecodable pattern on digit 3
    do_reset();
    pat[3] = 7'b1010101;
    fv_base = fv_cnt;
    scan(0, 7, 8);
    idle(4);
    check("inv_fv", fv_cnt - fv_base, 1);
    check("inv_flag", {31'h0, invalid_seen}, 32'h1);
    check("inv_nibble", {28'h0, frame_digits[15:12]}, 32'hE);
    check("inv_digits", frame_digits, 32'h8765E321);
    check("inv_blank", {24'h0, frame_blank}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
Receive-side counterpart of the scoreboard's multiplexed seven-segment display drive. It samples the active-low anode-select and segment buses and recovers the displayed value of each of the 8 digits. It assembles the digits into a complete frame and flags malformed scan activity. It sits beside the display controller as an on-chip readback and self-check monitor, and the benches also use it to check displayed scores and timer values.

Parameters:
SETTLE_CYCLES, 4, number of consecutive identical samples (after the first) required before a digit is captured; legal range is 1 to 255.
TIMEOUT_CYCLES, 1048576, maximum number of clocks between captures before the partial frame is discarded; legal range is at least 2.

Ports:
clock  input  1  system clock; the only clock.
reset  input  1  synchronous, active-high reset.
anode_activate  input  8  anode selects, active low; bit i low selects digit i.
led_out  input  7  segments, active low, ordered {a,b,c,d,e,f,g} with a at bit 6 and g at bit 0.
frame_digits  output  32  digit i value at bits [4i+3:4i].
frame_blank  output  8  bit i set if digit i was blank in the last frame.
frame_valid  output  1  one-cycle pulse when frame_digits and frame_blank update.
invalid_seen  output  1  sticky; set when an undecodable segment pattern is captured.
multi_anode_seen  output  1  sticky; set when two or more anodes are low in a stable sample.
scan_stall  output  1  level; set on timeout, cleared by the next capture.

Behaviour:
- Reset: all outputs are 0. The internal capture buffer, seen-mask, stable counter and timeout counter are cleared, and the FSM enters WAIT_STABLE. Reset asserted mid-frame discards the partial frame.
- Input stage: {anode_activate, led_out} is registered into samp each clock. stable_cnt increments while samp equals the previous samp and resets to 0 on any difference, saturating at 255.
- FSM WAIT_STABLE: when stable_cnt equals SETTLE_CYCLES, evaluate samp.
  - Exactly one anode low: capture and go to HOLD.
  - All anodes high: no capture; stay in WAIT_STABLE.
  - Two or more anodes low: set multi_anode_seen, no capture, go to HOLD.
- FSM HOLD: wait for samp to change (stable_cnt returns to 0), then go to WAIT_STABLE. Each anode-on period is therefore captured at most once.
- Segment decode (active low, bit6..bit0 = a..g):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100.
  - 1111111 is blank: value 4'hF and the blank bit set.
  - Any other pattern is invalid: value 4'hE, invalid_seen set, blank bit clear.
- Capture for digit i: buf[i] <= value, blank_buf[i] <= blank, seen[i] <= 1. Re-capturing a digit before the frame completes overwrites it; seen is unchanged.
- Frame completion: on the clock after the capture that makes seen == 8'hFF:
  - frame_digits <= buf and frame_blank <= blank_buf, both including the final capture.
  - frame_valid is asserted for exactly 1 cycle.
  - seen is cleared in the same cycle.
- Latency: the first samp of a new pattern is stable_cnt 0. Capture happens on the edge where stable_cnt reaches SETTLE_CYCLES. frame_valid is high 1 cycle after the final capture.
- Timeout:
  - tmo_cnt resets to 0 on every capture and otherwise increments.
  - When tmo_cnt reaches TIMEOUT_CYCLES-1: seen is cleared, scan_stall is set and tmo_cnt holds. frame_digits is not changed.
  - If a capture and the timeout occur in the same cycle, the capture wins: tmo_cnt resets and seen is not cleared.
- Sticky flags are cleared only by reset.

Optional Feature:
SEG_HEX_EN.
- Defined: patterns A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000 and F = 0111000 decode to 4'hA through 4'hF and do not set invalid_seen. In this mode an invalid pattern decodes to 4'hE and is distinguishable only by invalid_seen.
- Undefined: these six patterns are invalid as specified above.

Test Plan:
- Scan digits 0..7 showing 1,2,3,4,5,6,7,8, 8 clocks each, SETTLE_CYCLES=4 -> one frame_valid pulse, frame_digits = 32'h87654321, frame_blank = 0, no flags set.
- Same scan with digits 7..4 at 1111111 -> frame_blank = 8'hF0, frame_digits[31:16] = 16'hFFFF.
- Hold each digit for exactly 4 clocks (stable_cnt maxes at 3) -> no captures, no frame_valid; after TIMEOUT_CYCLES (set to 64) scan_stall = 1, and it clears on the next valid capture.
- A stable sample with anode = 8'b11111100 -> multi_anode_seen = 1 and seen unchanged; a subsequent complete scan still yields frame_valid.
- Digit 3 at pattern 1010101 -> invalid_seen = 1 and frame_digits[15:12] = 4'hE; with SEG_HEX_EN, digit 2 at 0001000 decodes to 4'hA with invalid_seen = 0.
- Assert reset after digits 0..5 have been captured, then scan only digits 6..7 -> no frame_valid; a full scan afterwards produces exactly one frame_valid.
